// File: rtl/iperm_pkg.sv
// iperm_pkg: shared constants, command field layout and FSM state for the permutation key generator
package iperm_pkg;
  localparam int LANES = 16;
  localparam int IDX_W = 4;
  localparam int CTRL_W = 4;
  localparam int KEY_W = LANES * IDX_W + CTRL_W;
  localparam int CMD_BASE_LSB = 0;
  localparam int CMD_STRIDE_LSB = 4;
  localparam int CMD_STEP_LSB = 8;
  localparam int CMD_CTRL_LSB = 12;
  localparam int CMD_CNT_LSB = 16;
  localparam int CMD_CNT_W = 16;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/iperm_key_calc.sv
// iperm_key_calc: combinational affine lane index map, idx_i = (base + i*stride) mod 16
module iperm_key_calc
  import iperm_pkg::*;
(
  input  logic [IDX_W-1:0]       i_base,
  input  logic [IDX_W-1:0]       i_stride,
  output logic [LANES*IDX_W-1:0] o_idx
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign o_idx[i*IDX_W +: IDX_W] = i_base + IDX_W'(i) * i_stride;
  end
endmodule

// File: rtl/iperm_key_gen.sv
// iperm_key_gen: expands affine commands into permutation key beats (IPERM_KEY_LAST_EN puts a last-beat flag in bit 67)
module iperm_key_gen
  import iperm_pkg::*;
#(
  parameter int CNT_W = CMD_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      t_cmd_dat,
  input  logic             t_cmd_valid,
  output logic             t_cmd_ready,
  output logic [KEY_W-1:0] i_kp_dat,
  output logic             i_kp_valid,
  input  logic             i_kp_ready,
  output logic             busy
);
  state_t                 r_state;
  logic [IDX_W-1:0]       r_base, r_stride, r_step;
  logic [CTRL_W-1:0]      r_ctrl;
  logic [CNT_W-1:0]       r_rem;
  logic [KEY_W-1:0]       r_dat;
  logic                   r_valid;
  logic                   w_idle, w_cmd_hs, w_kp_hs;
  logic [IDX_W-1:0]       w_cmd_base, w_cmd_stride, w_cmd_step, w_next_base;
  logic [CTRL_W-1:0]      w_cmd_ctrl, w_key_ctrl;
  logic [CNT_W-1:0]       w_cmd_cnt;
  logic [LANES*IDX_W-1:0] w_idx;

  assign w_cmd_base   = t_cmd_dat[CMD_BASE_LSB +: IDX_W];
  assign w_cmd_stride = t_cmd_dat[CMD_STRIDE_LSB +: IDX_W];
  assign w_cmd_step   = t_cmd_dat[CMD_STEP_LSB +: IDX_W];
  assign w_cmd_ctrl   = t_cmd_dat[CMD_CTRL_LSB +: CTRL_W];
  assign w_cmd_cnt    = t_cmd_dat[CMD_CNT_LSB +: CNT_W];
  assign w_idle       = (r_state == IDLE);
  assign w_cmd_hs     = t_cmd_valid & w_idle;
  assign w_kp_hs      = r_valid & i_kp_ready;
  assign w_next_base  = r_base + r_step;
  assign t_cmd_ready  = w_idle;
  assign busy         = ~w_idle;
  assign i_kp_valid   = r_valid;
  assign i_kp_dat     = r_dat;

  // One shared index calculator: the command fields feed it in IDLE, the advanced base in RUN
  iperm_key_calc u_calc (
    .i_base  (w_idle ? w_cmd_base : w_next_base),
    .i_stride(w_idle ? w_cmd_stride : r_stride),
    .o_idx   (w_idx)
  );

`ifdef IPERM_KEY_LAST_EN
  assign w_key_ctrl = w_idle ? {w_cmd_cnt == CNT_W'(1), w_cmd_ctrl[2:0]}
                             : {r_rem == CNT_W'(2), r_ctrl[2:0]};
`else
  assign w_key_ctrl = w_idle ? w_cmd_ctrl : r_ctrl;
`endif

  // Command/beat FSM; the key is registered one beat ahead so outputs carry no combinational path
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_dat    <= '0;
      r_base   <= '0;
      r_stride <= '0;
      r_step   <= '0;
      r_ctrl   <= '0;
      r_rem    <= '0;
    end else if (w_idle) begin
      if (w_cmd_hs && w_cmd_cnt != '0) begin
        r_state  <= RUN;
        r_valid  <= 1'b1;
        r_base   <= w_cmd_base;
        r_stride <= w_cmd_stride;
        r_step   <= w_cmd_step;
        r_ctrl   <= w_cmd_ctrl;
        r_rem    <= w_cmd_cnt;
        r_dat    <= {w_key_ctrl, w_idx};
      end
    end else if (w_kp_hs) begin
      if (r_rem == CNT_W'(1)) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
      end else begin
        r_base <= w_next_base;
        r_rem  <= r_rem - CNT_W'(1);
        r_dat  <= {w_key_ctrl, w_idx};
      end
    end
  end
endmodule

// File: tb/tb_iperm_key_gen.sv
// tb_iperm_key_gen: directed table-driven checks of the key generator plus backpressure, zero-count and reset sequences
module tb_iperm_key_gen;
  logic        clk;
  logic        reset_n;
  logic [31:0] t_cmd_dat;
  logic        t_cmd_valid;
  logic        t_cmd_ready;
  logic [67:0] i_kp_dat;
  logic        i_kp_valid;
  logic        i_kp_ready;
  logic        busy;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [67:0] got[$];

  typedef struct {
    logic [31:0] cmd;
    logic [67:0] exp0;
    logic [67:0] expl;
    int          beats;
  } vec_t;

  vec_t vecs[7];

  iperm_key_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .t_cmd_dat  (t_cmd_dat),
    .t_cmd_valid(t_cmd_valid),
    .t_cmd_ready(t_cmd_ready),
    .i_kp_dat   (i_kp_dat),
    .i_kp_valid (i_kp_valid),
    .i_kp_ready (i_kp_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] fix(input logic [67:0] k, input bit last);
`ifdef IPERM_KEY_LAST_EN
    k[67] = last;
`endif
    return k;
  endfunction

  function automatic logic [67:0] model(input logic [3:0] b, input logic [3:0] s,
                                       input logic [3:0] ctl, input bit last);
    logic [67:0] k;
    k[67:64] = ctl;
    for (int i = 0; i < 16; i++) k[i*4 +: 4] = 4'(int'(b) + i * int'(s));
    return fix(k, last);
  endfunction

  task automatic send_cmd(input logic [31:0] cmd);
    int w = 0;
    @(negedge clk);
    t_cmd_dat = cmd;
    t_cmd_valid = 1'b1;
    while (!t_cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cmd_accept", 68'(t_cmd_ready), 68'(1));
    @(posedge clk);
    #1 t_cmd_valid = 1'b0;
  endtask

  task automatic collect(input int maxb);
    got.delete();
    i_kp_ready = 1'b1;
    for (int c = 0; c < maxb + 3; c++) begin
      @(negedge clk);
      if (!i_kp_valid) break;
      got.push_back(i_kp_dat);
    end
  endtask

  initial begin
    logic [31:0] c;
    logic [67:0] prev;
    int          hold;
    vecs[0] = '{32'h0001_2010, 68'h2_FEDCBA9876543210, 68'h2_FEDCBA9876543210, 1};
    vecs[1] = '{32'h0003_011E, 68'h0_DCBA9876543210FE, 68'h0_FEDCBA9876543210, 3};
    vecs[2] = '{32'h0001_5030, 68'h5_DA741EB852FC9630, 68'h5_DA741EB852FC9630, 1};
    vecs[3] = '{32'h0002_A421, 68'hA_FDB97531FDB97531, 68'hA_31FDB97531FDB975, 2};
    vecs[4] = '{32'h0001_F007, 68'hF_7777777777777777, 68'hF_7777777777777777, 1};
    vecs[5] = '{32'h0001_00F0, 68'h0_123456789ABCDEF0, 68'h0_123456789ABCDEF0, 1};
    vecs[6] = '{32'h0003_F010, 68'hF_FEDCBA9876543210, 68'hF_FEDCBA9876543210, 3};

    reset_n = 1'b0;
    t_cmd_dat = '0;
    t_cmd_valid = 1'b0;
    i_kp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 68'(i_kp_valid), 68'(0));
    chk("rst_dat", i_kp_dat, 68'h0);
    chk("rst_busy", 68'(busy), 68'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", 68'(t_cmd_ready), 68'(1));

    for (int v = 0; v < 7; v++) begin
      c = vecs[v].cmd;
      send_cmd(c);
      collect(vecs[v].beats);
      chk($sformatf("v%0d_beats", v), 68'(got.size()), 68'(vecs[v].beats));
      chk($sformatf("v%0d_bubble_ready", v), 68'(t_cmd_ready), 68'(1));
      if (got.size() > 0) begin
        chk($sformatf("v%0d_first", v), got[0], fix(vecs[v].exp0, vecs[v].beats == 1));
        chk($sformatf("v%0d_last", v), got[got.size()-1], fix(vecs[v].expl, 1'b1));
      end
      for (int b = 0; b < got.size(); b++)
        chk($sformatf("v%0d_beat%0d", v, b), got[b],
            model(4'(int'(c[3:0]) + b * int'(c[11:8])), c[7:4], c[15:12], b == vecs[v].beats - 1));
    end

    send_cmd(32'h0004_3110);
    got.delete();
    hold = 0;
    prev = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!i_kp_valid) break;
      if (got.size() == 1 && hold < 5) begin
        i_kp_ready = 1'b0;
        if (hold > 0) chk("bp_hold", i_kp_dat, prev);
        chk("bp_cmd_stall", 68'(t_cmd_ready), 68'(0));
        prev = i_kp_dat;
        hold++;
      end else begin
        i_kp_ready = 1'b1;
        got.push_back(i_kp_dat);
      end
    end
    i_kp_ready = 1'b1;
    chk("bp_beats", 68'(got.size()), 68'(4));
    for (int b = 0; b < got.size(); b++)
      chk($sformatf("bp_beat%0d", b), got[b], model(4'(b), 4'h1, 4'h3, b == 3));

    send_cmd(32'h0000_2010);
    repeat (3) begin
      @(negedge clk);
      chk("zc_valid", 68'(i_kp_valid), 68'(0));
      chk("zc_ready", 68'(t_cmd_ready), 68'(1));
    end
    send_cmd(32'h0001_7010);
    @(negedge clk);
    chk("zc_next_valid", 68'(i_kp_valid), 68'(1));
    chk("zc_next_dat", i_kp_dat, fix(68'h7_FEDCBA9876543210, 1'b1));
    @(negedge clk);
    chk("zc_next_done", 68'(i_kp_valid), 68'(0));

    send_cmd(32'h000A_0110);
    repeat (3) @(negedge clk);
    chk("rr_valid_before", 68'(i_kp_valid), 68'(1));
    chk("rr_dat_before", i_kp_dat, model(4'h2, 4'h1, 4'h0, 1'b0));
    #2 reset_n = 1'b0;
    #1;
    chk("rr_valid_async", 68'(i_kp_valid), 68'(0));
    chk("rr_busy_async", 68'(busy), 68'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rr_no_stale", 68'(i_kp_valid), 68'(0));
      chk("rr_ready", 68'(t_cmd_ready), 68'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
